noise_matrix_filler_mc: RTL and testbench
=========================================

NOISE_MATRIX_FILLER_MC -- requirements
Module: noise_matrix_filler_mc

Interface
REQ-001 SHALL expose parameter DATA_WIDTH, default 16, meaning width of each noise sample written to BRAM (8..32).
REQ-002 SHALL expose parameter ADDR_WIDTH, default 14, meaning BRAM word-address width.
REQ-003 SHALL expose parameter NUM_CH, default 1, meaning number of channel matrices filled per run (1..8), stored channel-major.
REQ-004 SHALL have clk  input  1  rising-edge clock; the only clock in the block.
REQ-005 SHALL have rst  input  1  synchronous active-high reset.
REQ-006 SHALL have start  input  1  single-cycle request to begin a fill; ignored unless idle.
REQ-007 SHALL have abort  input  1  terminates a running fill.
REQ-008 SHALL have size  input  3  matrix-dimension code; D = 4 << size.
REQ-009 SHALL have seed  input  32  LFSR seed, sampled with start.
REQ-010 SHALL have bram_ready  input  1  BRAM accepts the write this cycle.
REQ-011 SHALL have bram_addr  output  ADDR_WIDTH  write address.
REQ-012 SHALL have bram_wdata  output  DATA_WIDTH  write data.
REQ-013 SHALL have bram_we  output  1  write request.
REQ-014 SHALL have busy  output  1  high from LOAD through FILL.
REQ-015 SHALL have done  output  1  one-cycle pulse on normal completion.
REQ-016 SHALL have err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-017 SHALL implement states IDLE, LOAD, FILL, DONE; IDLE->LOAD on start, LOAD->FILL after one cycle, FILL->DONE after the last accepted write, DONE->IDLE after one cycle.
REQ-018 SHALL reject start (pulse err on the following cycle, remain IDLE, no write) when size > 5 or NUM_CH*D*D > 2^ADDR_WIDTH.
REQ-019 SHALL, in LOAD, load the 32-bit Galois LFSR (taps 0x80200003) with seed, substituting 0xACE1ACE1 when seed = 0.
REQ-020 SHALL assert bram_we continuously in FILL; first bram_we is the second cycle after start is sampled.
REQ-021 SHALL count a write as accepted only in a cycle with bram_we && bram_ready; bram_addr and bram_wdata SHALL hold unchanged while bram_ready is low.
REQ-022 SHALL generate address ch*D*D + row*D + col, col incrementing fastest, then row, then ch; address zero-extended to ADDR_WIDTH.
REQ-023 SHALL advance the LFSR exactly once per accepted write (uniform mode); bram_wdata = LFSR[DATA_WIDTH-1:0] of the current state.
REQ-024 SHALL write exactly NUM_CH*D*D words per run, the last at address NUM_CH*D*D-1, with done pulsing the cycle after DONE is entered.
REQ-025 SHALL, on abort high in LOAD or FILL, return to IDLE next cycle with bram_we low and no done; abort in IDLE/DONE has no effect; abort wins over a simultaneous accepted write (that write still counts at the BRAM).
REQ-026 SHALL ignore start while busy or in DONE; start in the same cycle done pulses is ignored.
REQ-027 SHALL keep the LFSR state after completion so that a new start reseeds it.

Reset
REQ-028 SHALL, with rst high at a clock edge, enter IDLE and drive bram_addr=0, bram_wdata=0, bram_we=0, busy=0, done=0, err=0, LFSR=0xACE1ACE1.
REQ-029 SHALL treat rst mid-fill as an immediate return to IDLE with no done or err pulse; rst overrides start and abort.

Configuration
REQ-030 SHALL, when macro NOISE_GAUSS_APPROX_EN is defined, advance the LFSR four steps per accepted write and output the arithmetic-right-shift-by-2 of the sum of the four signed DATA_WIDTH lower slices (sum computed at DATA_WIDTH+2 bits, result signed DATA_WIDTH).
REQ-031 SHALL, when NOISE_GAUSS_APPROX_EN is undefined, use uniform mode per REQ-023 with no extra logic; handshake, addressing and timing are identical in both builds.

Verification
REQ-032 SHALL cover: size=0, NUM_CH=1, seed=1, bram_ready=1 -> 16 writes at addresses 0..15 on consecutive cycles, first bram_we 2 cycles after start, done pulse once.
REQ-033 SHALL cover: size=5, NUM_CH=1, ADDR_WIDTH=14 -> 16384 writes, last address 16383; same with NUM_CH=2 -> err pulse, no writes.
REQ-034 SHALL cover: size=6 -> err pulse, busy never high.
REQ-035 SHALL cover: bram_ready toggling 1,0,0,1 during FILL -> addr/wdata held during low cycles, no skipped or duplicated address, data matches software LFSR model.
REQ-036 SHALL cover: abort asserted after 5 accepted writes, size=2 -> bram_we low next cycle, no done; subsequent start with seed=0 restarts at address 0 with LFSR 0xACE1ACE1.
REQ-037 SHALL cover: rst asserted mid-fill then start re-issued -> all outputs at reset values, refill completes normally.

Source files
------------

// File: rtl/noise_matrix_filler_mc.sv
// noise_matrix_filler_mc: fills NUM_CH square D x D matrices (D = 4 << size)
// in BRAM with LFSR noise, one word per accepted write, channel-major order.
// Optional feature macro: NOISE_GAUSS_APPROX_EN (four-step LFSR sum giving an
// approximately Gaussian sample); undefined gives uniform samples.
//
// Handshake: a write is transferred in every cycle where bram_we && bram_ready
// are both high at the rising edge; while bram_ready is low, bram_addr and
// bram_wdata hold their values and bram_we stays high.
module noise_matrix_filler_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_CH     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            size,
  input  logic [31:0]           seed,
  input  logic                  bram_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  bram_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'hACE1_ACE1;

  state_t                  state_q, state_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [31:0]             seed_q, seed_d;
  logic [ADDR_WIDTH-1:0]   last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [4:0]              shamt;
  logic [39:0]             req_words;
  logic                    req_ok;
  logic                    accept;
  logic [31:0]             seed_eff;
  logic [31:0]             lfsr_adv;

  // One Galois step, shifting right with the tap mask applied on a one out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // LFSR state that follows one accepted write.
  function automatic logic [31:0] gen_next(input logic [31:0] s);
`ifdef NOISE_GAUSS_APPROX_EN
    gen_next = lfsr_step(lfsr_step(lfsr_step(lfsr_step(s))));
`else
    gen_next = lfsr_step(s);
`endif
  endfunction

  // Sample written for LFSR state s.
  function automatic logic [DATA_WIDTH-1:0] gen_data(input logic [31:0] s);
`ifdef NOISE_GAUSS_APPROX_EN
    logic [31:0]             s1, s2, s3;
    logic [DATA_WIDTH+1:0]   acc;
    s1  = lfsr_step(s);
    s2  = lfsr_step(s1);
    s3  = lfsr_step(s2);
    // Sign-extend each slice by two bits so the four-way sum cannot overflow.
    acc = {{2{s[DATA_WIDTH-1]}},  s[DATA_WIDTH-1:0]}
        + {{2{s1[DATA_WIDTH-1]}}, s1[DATA_WIDTH-1:0]}
        + {{2{s2[DATA_WIDTH-1]}}, s2[DATA_WIDTH-1:0]}
        + {{2{s3[DATA_WIDTH-1]}}, s3[DATA_WIDTH-1:0]};
    // Arithmetic shift right by two; the quarter of the sum fits DATA_WIDTH.
    gen_data = acc[DATA_WIDTH+1:2];
`else
    gen_data = s[DATA_WIDTH-1:0];
`endif
  endfunction

  // Request sizing and write acceptance.
  always_comb begin
    shamt     = 5'({size, 1'b0}) + 5'd4;
    req_words = 40'(NUM_CH) << shamt;
    req_ok    = (size <= 3'd5) && (req_words <= (40'd1 << ADDR_WIDTH));
    accept    = we_q && bram_ready;
    seed_eff  = (seed_q == 32'd0) ? LFSR_INIT : seed_q;
    lfsr_adv  = gen_next(lfsr_q);
  end

  // Next-state and registered-output computation for the fill sequencer.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // done_q high means the DONE cycle just ended; a start there is dropped.
        if (start && !done_q) begin
          if (req_ok) begin
            state_d = S_LOAD;
            seed_d  = seed;
            last_d  = ADDR_WIDTH'(req_words - 40'd1);
            busy_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_FILL;
          lfsr_d  = seed_eff;
          addr_d  = '0;
          wdata_d = gen_data(seed_eff);
          we_d    = 1'b1;
        end
      end
      S_FILL: begin
        if (abort) begin
          // A write accepted on this edge still lands; the run simply stops.
          state_d = S_IDLE;
          we_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (accept) begin
          lfsr_d = lfsr_adv;
          if (addr_q == last_q) begin
            state_d = S_DONE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
          end else begin
            addr_d  = addr_q + 1'b1;
            wdata_d = gen_data(lfsr_adv);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_INIT;
      seed_q  <= 32'd0;
      last_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign bram_we    = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_noise_matrix_filler_mc.sv
// Bench for noise_matrix_filler_mc: directed steps in one initial block,
// expected writes queued from a software LFSR model and checked on output.
module tb_noise_matrix_filler_mc;

  localparam int DW = 16;
  localparam int AW = 14;
  localparam int W  = AW + DW;

  logic          clk = 1'b0;
  logic          rst, start, start2, abort, bram_ready;
  logic [2:0]    size;
  logic [31:0]   seed;
  logic [AW-1:0] bram_addr, bram_addr2;
  logic [DW-1:0] bram_wdata, bram_wdata2;
  logic          bram_we, busy, done, err;
  logic          bram_we2, busy2, done2, err2;
  logic [1:0]    dbg_state, dbg_state2;

  logic [W-1:0]  exp_q[$];
  int            total_cnt = 0;
  int            bad_cnt   = 0;
  int            acc_cnt   = 0;
  int            done_cnt  = 0;
  int            busy_cnt  = 0;
  int            we2_cnt   = 0;
  int            ready_mode = 0;
  int            cyc = 0;
  logic [AW-1:0] last_addr = '0;
  logic [3:0]    ready_pat = 4'b1001;

  noise_matrix_filler_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .size(size),
    .seed(seed), .bram_ready(bram_ready), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_we(bram_we), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state));

  noise_matrix_filler_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .size(size),
    .seed(seed), .bram_ready(bram_ready), .bram_addr(bram_addr2),
    .bram_wdata(bram_wdata2), .bram_we(bram_we2), .busy(busy2), .done(done2),
    .err(err2), .dbg_state(dbg_state2));

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) else begin
      bad_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Queue every write of a NUM_CH=1 run from the reference LFSR.
  task automatic push_run(input logic [31:0] sd, input int sz);
    logic [31:0] s;
    logic [DW-1:0] d;
    int n;
    s = (sd == 32'd0) ? 32'hACE1_ACE1 : sd;
    n = (4 << sz) * (4 << sz);
    for (int i = 0; i < n; i++) begin
`ifdef NOISE_GAUSS_APPROX_EN
      begin
        int sum;
        logic [31:0] t;
        sum = 0;
        t = s;
        for (int k = 0; k < 4; k++) begin
          sum += int'($signed(t[DW-1:0]));
          t = m_step(t);
        end
        d = DW'(sum >>> 2);
        s = t;
      end
`else
      d = s[DW-1:0];
      s = m_step(s);
`endif
      exp_q.push_back({AW'(i), d});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0) break;
    end
    tick();
    tick();
    check(tag, 32'(done_cnt - d0), 32'd1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_start(input int sz, input logic [31:0] sd);
    size  = 3'(sz);
    seed  = sd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(bram_addr),  32'd0);
    check({tag, "_wdata"}, 32'(bram_wdata), 32'd0);
    check({tag, "_we"},    32'(bram_we),    32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_state"}, 32'(dbg_state),  32'd0);
  endtask

  // bram_ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    bram_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        1:       bram_ready = ready_pat[cyc % 4];
        2:       bram_ready = 1'($urandom_range(0, 1));
        default: bram_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard: compare every offered write with the queue head; pop on accept.
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_we) begin
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check(bram_ready ? "write_data" : "held_data",
                32'({bram_addr, bram_wdata}), 32'(exp_q[0]));
          if (bram_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
            last_addr = bram_addr;
          end
        end
      end
      if (done)     done_cnt++;
      if (busy)     busy_cnt++;
      if (bram_we2) we2_cnt++;
    end
  end

  initial begin
    int a0, d0;
    logic [31:0] rs;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
    size = 3'd0; seed = 32'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Smallest matrix, always ready: first write two cycles after start.
    push_run(32'd1, 0);
    a0 = acc_cnt;
    do_start(0, 32'd1);
    check("load_we", 32'(bram_we), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    tick();
    check("first_we", 32'(bram_we), 32'd1);
    check("first_addr", 32'(bram_addr), 32'd0);
    wait_done("size0_done", 40);
    check("size0_writes", 32'(acc_cnt - a0), 32'd16);
    check("size0_last", 32'(last_addr), 32'd15);

    // Largest matrix filling the whole address space.
    push_run(32'h1234_5678, 5);
    a0 = acc_cnt;
    do_start(5, 32'h1234_5678);
    wait_done("size5_done", 17000);
    check("size5_writes", 32'(acc_cnt - a0), 32'd16384);
    check("size5_last", 32'(last_addr), 32'd16383);

    // Two channels of the largest matrix do not fit: rejected.
    we2_cnt = 0;
    size = 3'd5;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("nch2_err", 32'(err2), 32'd1);
    check("nch2_busy", 32'(busy2), 32'd0);
    tick();
    check("nch2_err_pulse", 32'(err2), 32'd0);
    tick();
    check("nch2_no_writes", 32'(we2_cnt), 32'd0);

    // Illegal size code: rejected, never busy.
    busy_cnt = 0;
    do_start(6, 32'h5);
    check("size6_err", 32'(err), 32'd1);
    tick();
    check("size6_err_pulse", 32'(err), 32'd0);
    tick();
    tick();
    check("size6_busy_never", 32'(busy_cnt), 32'd0);
    check("size6_idle", 32'(dbg_state), 32'd0);

    // bram_ready toggling 1,0,0,1; a stray start mid-fill must be ignored.
    ready_mode = 1;
    push_run(32'hC0FF_EE01, 1);
    a0 = acc_cnt;
    do_start(1, 32'hC0FF_EE01);
    for (int i = 0; i < 10; i++) tick();
    do_start(0, 32'h7);
    wait_done("toggle_done", 400);
    check("toggle_writes", 32'(acc_cnt - a0), 32'd64);

    // Random ready with random seed.
    ready_mode = 2;
    rs = $urandom_range(1, 32'h7fff_ffff);
    push_run(rs, 0);
    do_start(0, rs);
    wait_done("rand_done", 400);
    ready_mode = 0;
    tick();

    // Abort after five accepted writes.
    push_run(32'hDEAD_BEEF, 2);
    a0 = acc_cnt;
    d0 = done_cnt;
    do_start(2, 32'hDEAD_BEEF);
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt - a0 >= 5) break;
      tick();
    end
    check("abort_five", 32'(acc_cnt - a0), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_we", 32'(bram_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    tick();
    tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_writes", 32'(acc_cnt - a0), 32'd6);
    exp_q.delete();

    // Restart with seed 0 uses the default seed from address 0.
    push_run(32'd0, 0);
    do_start(0, 32'd0);
    wait_done("seed0_done", 40);

    // Reset in the middle of a fill, then a normal refill.
    push_run(32'h0BAD_F00D, 2);
    d0 = done_cnt;
    do_start(2, 32'h0BAD_F00D);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    push_run(32'h0000_0042, 1);
    a0 = acc_cnt;
    do_start(1, 32'h0000_0042);
    wait_done("refill_done", 200);
    check("refill_writes", 32'(acc_cnt - a0), 32'd64);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
